// File: rtl/confreg_uart_if.sv
// Data-side conf_* bus plus the UART/timer side signals of the confreg slave.
// The slave modport is the confreg view; master is the CPU/bench view.
interface confreg_uart_if;
    logic        conf_en;
    logic [7:0]  conf_wen;
    logic [63:0] conf_addr;
    logic [63:0] conf_wdata;
    logic [63:0] conf_rdata;
    logic        uart_out_valid;
    logic [7:0]  uart_out_ch;
    logic        uart_in_valid;
    logic [7:0]  uart_in_ch;
    logic        timer_irq;

    modport slave (
        input  conf_en, conf_wen, conf_addr, conf_wdata, uart_in_ch,
        output conf_rdata, uart_out_valid, uart_out_ch, uart_in_valid, timer_irq
    );

    modport master (
        output conf_en, conf_wen, conf_addr, conf_wdata, uart_in_ch,
        input  conf_rdata, uart_out_valid, uart_out_ch, uart_in_valid, timer_irq
    );
endinterface

// File: rtl/confreg_uart.sv
// Confreg slave: UART TX FIFO with paced drain, RX poll register and a 64-bit
// mtime/mtimecmp timer with a registered interrupt. Reads return one cycle later.
module confreg_uart #(
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_1000_0000,
    parameter int          DEPTH     = 16,
    parameter int          TX_GAP    = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    confreg_uart_if.slave conf
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [7:0]  OFF_TXDATA   = 8'h00;
    localparam logic [7:0]  OFF_STATUS   = 8'h08;
    localparam logic [7:0]  OFF_RXDATA   = 8'h10;
    localparam logic [7:0]  OFF_MTIME    = 8'h18;
    localparam logic [7:0]  OFF_MTIMECMP = 8'h20;
    localparam logic [15:0] GAP_LOAD     = 16'(TX_GAP);

    logic          w_sel;
    logic          w_wr;
    logic          w_rd;
    logic [7:0]    w_off;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_push_req;
    logic          w_push;
    logic          w_ovf_set;
    logic          w_ovf_clr;
    logic [63:0]   w_rd_val;
    logic [63:0]   w_mtime_nxt;
    logic [63:0]   w_mtimecmp_nxt;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic          r_ovf;
    logic [15:0]   r_gap;
    logic [63:0]   r_mtime;
    logic [63:0]   r_mtimecmp;
    logic [63:0]   r_rdata;
    logic          r_out_valid;
    logic [7:0]    r_out_ch;
    logic          r_irq;

    function automatic logic [63:0] merge_bytes(input logic [63:0] old_v,
                                                input logic [63:0] new_v,
                                                input logic [7:0]  be);
        logic [63:0] res;
        res = old_v;
        for (int i = 0; i < 8; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_v[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_v[8*i +: 8];
            end
        end
        return res;
    endfunction

    // Address decode and FIFO push/pop/overflow decisions.
    always_comb begin
        w_off      = conf.conf_addr[7:0];
        w_sel      = conf.conf_en & (conf.conf_addr[63:8] == BASE_ADDR[63:8]);
        w_wr       = w_sel & (|conf.conf_wen);
        w_rd       = w_sel & ~(|conf.conf_wen);
        w_full     = (r_count == CW'(DEPTH));
        w_empty    = (r_count == CW'(0));
        w_pop      = ~w_empty & (r_gap == 16'd0);
        w_push_req = w_wr & (w_off == OFF_TXDATA) & conf.conf_wen[0];
        // a pop in the same cycle frees the slot a full FIFO needs
        w_push     = w_push_req & (~w_full | w_pop);
        w_ovf_set  = w_push_req & w_full & ~w_pop;
        w_ovf_clr  = w_wr & (w_off == OFF_STATUS) & conf.conf_wen[0] & conf.conf_wdata[2];
    end

    // Read data mux; unmapped offsets read as zero.
    always_comb begin
        case (w_off)
            OFF_STATUS:   w_rd_val = {48'h0, 8'(r_count), 5'h0, r_ovf, w_empty, w_full};
            OFF_RXDATA:   w_rd_val = {56'h0, conf.uart_in_ch};
            OFF_MTIME:    w_rd_val = r_mtime;
            OFF_MTIMECMP: w_rd_val = r_mtimecmp;
            default:      w_rd_val = 64'h0;
        endcase
    end

    // Next timer values: a write to mtime suppresses that cycle's increment.
    always_comb begin
        if (w_wr && (w_off == OFF_MTIME)) begin
            w_mtime_nxt = merge_bytes(r_mtime, conf.conf_wdata, conf.conf_wen);
        end else begin
            w_mtime_nxt = r_mtime + 64'd1;
        end
        if (w_wr && (w_off == OFF_MTIMECMP)) begin
            w_mtimecmp_nxt = merge_bytes(r_mtimecmp, conf.conf_wdata, conf.conf_wen);
        end else begin
            w_mtimecmp_nxt = r_mtimecmp;
        end
    end

    // TX FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
            r_head  <= AW'(0);
            r_tail  <= AW'(0);
            r_count <= CW'(0);
        end else begin
            if (w_push) begin
                r_mem[r_tail] <= conf.conf_wdata[7:0];
                r_tail        <= r_tail + AW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end else begin
                r_count <= r_count;
            end
        end
    end

    // TX output pulse, pacing gap and sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_ch    <= 8'h00;
            r_gap       <= 16'd0;
            r_ovf       <= 1'b0;
        end else begin
            r_out_valid <= w_pop;
            if (w_pop) begin
                r_out_ch <= r_mem[r_head];
                r_gap    <= GAP_LOAD;
            end else if (r_gap != 16'd0) begin
                r_gap <= r_gap - 16'd1;
            end else begin
                r_gap <= r_gap;
            end
            r_ovf <= w_ovf_set | (r_ovf & ~w_ovf_clr);
        end
    end

    // Timer registers, interrupt and read data register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mtime    <= 64'h0;
            r_mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
            r_irq      <= 1'b0;
            r_rdata    <= 64'h0;
        end else begin
            r_mtime    <= w_mtime_nxt;
            r_mtimecmp <= w_mtimecmp_nxt;
            r_irq      <= (w_mtime_nxt >= w_mtimecmp_nxt);
            if (w_rd) begin
                r_rdata <= w_rd_val;
            end
        end
    end

    assign conf.conf_rdata     = r_rdata;
    assign conf.uart_out_valid = r_out_valid;
    assign conf.uart_out_ch    = r_out_ch;
    assign conf.uart_in_valid  = w_rd & (w_off == OFF_RXDATA);
    assign conf.timer_irq      = r_irq;
endmodule

// File: tb/tb_confreg_uart.sv
// Bench for confreg_uart: two instances (TX_GAP 0 and 4) share one stimulus stream
// and are compared each cycle against a queue-based reference model.
module tb_confreg_uart;
    localparam logic [63:0] BASE  = 64'h0000_0000_1000_0000;
    localparam int          DEPTH = 16;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        t_en    = 1'b0;
    logic [7:0]  t_wen   = 8'h00;
    logic [63:0] t_addr  = 64'h0;
    logic [63:0] t_wdata = 64'h0;
    logic [7:0]  t_in_ch = 8'h00;

    int checks   = 0;
    int failures = 0;

    confreg_uart_if if0 ();
    confreg_uart_if if4 ();

    assign if0.conf_en    = t_en;
    assign if0.conf_wen   = t_wen;
    assign if0.conf_addr  = t_addr;
    assign if0.conf_wdata = t_wdata;
    assign if0.uart_in_ch = t_in_ch;
    assign if4.conf_en    = t_en;
    assign if4.conf_wen   = t_wen;
    assign if4.conf_addr  = t_addr;
    assign if4.conf_wdata = t_wdata;
    assign if4.uart_in_ch = t_in_ch;

    confreg_uart #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .TX_GAP(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .conf(if0));
    confreg_uart #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .TX_GAP(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .conf(if4));

    always #5 clk = ~clk;

    // Reference model state, index 0 = TX_GAP 0, index 1 = TX_GAP 4
    logic [7:0]  m_q0[$];
    logic [7:0]  m_q4[$];
    logic        m_ovf   [2];
    int          m_gap   [2];
    logic [63:0] m_mtime [2];
    logic [63:0] m_cmp   [2];
    logic [63:0] m_rdata [2];
    logic        m_valid [2];
    logic [7:0]  m_ch    [2];
    logic        m_irq   [2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q0.delete();
        m_q4.delete();
        for (int k = 0; k < 2; k++) begin
            m_ovf[k] = 1'b0; m_gap[k] = 0; m_mtime[k] = 64'h0;
            m_cmp[k] = 64'hFFFF_FFFF_FFFF_FFFF; m_rdata[k] = 64'h0;
            m_valid[k] = 1'b0; m_ch[k] = 8'h00; m_irq[k] = 1'b0;
        end
    endtask

    task automatic model_step(input int k, input int gap_ld);
        logic [7:0]  q[$];
        int          cnt;
        bit          sel, wr, rd, pop;
        logic [7:0]  off;
        logic [63:0] rv, nm, nc;
        if (k == 0) q = m_q0; else q = m_q4;
        cnt = q.size();
        sel = t_en && (t_addr[63:8] == BASE[63:8]);
        wr  = sel && (t_wen != 8'h00);
        rd  = sel && (t_wen == 8'h00);
        off = t_addr[7:0];
        case (off)
            8'h08:   rv = 64'(cnt) * 64'd256 + (m_ovf[k] ? 64'd4 : 64'd0)
                          + ((cnt == 0) ? 64'd2 : 64'd0) + ((cnt == DEPTH) ? 64'd1 : 64'd0);
            8'h10:   rv = 64'(t_in_ch);
            8'h18:   rv = m_mtime[k];
            8'h20:   rv = m_cmp[k];
            default: rv = 64'h0;
        endcase
        if (rd) m_rdata[k] = rv;
        pop = (cnt != 0) && (m_gap[k] == 0);
        m_valid[k] = pop;
        if (pop) m_ch[k] = q.pop_front();
        if (wr && off == 8'h00 && t_wen[0]) begin
            if (cnt < DEPTH || pop) q.push_back(t_wdata[7:0]);
            else m_ovf[k] = 1'b1;
        end else if (wr && off == 8'h08 && t_wen[0] && t_wdata[2]) begin
            m_ovf[k] = 1'b0;
        end
        m_gap[k] = pop ? gap_ld : ((m_gap[k] > 0) ? m_gap[k] - 1 : 0);
        nm = m_mtime[k] + 64'd1;
        nc = m_cmp[k];
        if (wr && off == 8'h18) begin
            nm = m_mtime[k];
            for (int b = 0; b < 8; b++) if (t_wen[b]) nm[8*b +: 8] = t_wdata[8*b +: 8];
        end
        if (wr && off == 8'h20) begin
            for (int b = 0; b < 8; b++) if (t_wen[b]) nc[8*b +: 8] = t_wdata[8*b +: 8];
        end
        m_mtime[k] = nm;
        m_cmp[k]   = nc;
        m_irq[k]   = (nm >= nc);
        if (k == 0) m_q0 = q; else m_q4 = q;
    endtask

    // Model advance on every active edge or reset assertion
    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else begin
                model_step(0, 0);
                model_step(1, 4);
            end
        end
    end

    // Per-cycle comparison of both instances against the model
    initial begin
        logic exp_in_valid;
        forever begin
            @(negedge clk);
            exp_in_valid = t_en && (t_addr[63:8] == BASE[63:8]) && (t_wen == 8'h00) && (t_addr[7:0] == 8'h10);
            chk("g0_rdata", if0.conf_rdata, m_rdata[0]);
            chk("g0_valid", 64'(if0.uart_out_valid), 64'(m_valid[0]));
            if (m_valid[0]) chk("g0_ch", 64'(if0.uart_out_ch), 64'(m_ch[0]));
            chk("g0_inval", 64'(if0.uart_in_valid), 64'(exp_in_valid));
            chk("g0_irq", 64'(if0.timer_irq), 64'(m_irq[0]));
            chk("g4_rdata", if4.conf_rdata, m_rdata[1]);
            chk("g4_valid", 64'(if4.uart_out_valid), 64'(m_valid[1]));
            if (m_valid[1]) chk("g4_ch", 64'(if4.uart_out_ch), 64'(m_ch[1]));
            chk("g4_inval", 64'(if4.uart_in_valid), 64'(exp_in_valid));
            chk("g4_irq", 64'(if4.timer_irq), 64'(m_irq[1]));
        end
    end

    task automatic acc_raw(input logic [63:0] addr, input logic [7:0] wen, input logic [63:0] wdata);
        t_en = 1'b1; t_wen = wen; t_addr = addr; t_wdata = wdata;
        @(posedge clk); #1;
        t_en = 1'b0; t_wen = 8'h00;
    endtask

    task automatic acc(input logic [7:0] off, input logic [7:0] wen, input logic [63:0] wdata);
        acc_raw(BASE | 64'(off), wen, wdata);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        logic [7:0] offs [8];
        bit found;
        offs = '{8'h00, 8'h08, 8'h10, 8'h18, 8'h20, 8'h28, 8'h04, 8'h30};
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_rdata", if0.conf_rdata, 64'h0);
        chk("rst_irq", 64'(if4.timer_irq), 64'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Two back-to-back TX writes, no gap
        acc(8'h00, 8'h01, 64'h48);
        acc(8'h00, 8'h01, 64'h69);
        @(negedge clk);
        chk("t1_v0", 64'(if0.uart_out_valid), 64'h1);
        chk("t1_c0", 64'(if0.uart_out_ch), 64'h48);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t1_v1", 64'(if0.uart_out_valid), 64'h1);
        chk("t1_c1", 64'(if0.uart_out_ch), 64'h69);
        idle(12);

        // Burst of 22 bytes: gap-4 instance fills, drops one, then push+pop at full
        for (int i = 0; i < 22; i++) acc(8'h00, 8'h01, 64'(8'h30 + 8'(i)));
        acc(8'h08, 8'h00, 64'h0);
        @(negedge clk);
        chk("t2_status", if4.conf_rdata, 64'h1005);
        acc(8'h08, 8'h01, 64'h4);
        acc(8'h08, 8'h00, 64'h0);
        @(negedge clk);
        chk("t2_ovfclr", if4.conf_rdata, 64'h1001);
        idle(95);

        // Timer write/read, compare interrupt, and wrap
        acc(8'h18, 8'hFF, 64'h100);
        idle(3);
        acc(8'h18, 8'h00, 64'h0);
        @(negedge clk);
        chk("t4_mtime", if0.conf_rdata, 64'h103);
        acc(8'h20, 8'hFF, 64'h110);
        @(negedge clk);
        chk("t4_irq_lo", 64'(if0.timer_irq), 64'h0);
        idle(20);
        chk("t4_irq_hi", 64'(if0.timer_irq), 64'h1);
        acc(8'h20, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk);
        chk("t4_irq_fall", 64'(if0.timer_irq), 64'h0);
        acc(8'h18, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFE);
        idle(2);
        acc(8'h18, 8'h00, 64'h0);
        @(negedge clk);
        chk("t4_wrap", if0.conf_rdata, 64'h0);

        // RX poll and unmapped offset
        t_in_ch = 8'h41;
        t_en = 1'b1; t_wen = 8'h00; t_addr = BASE | 64'h10;
        #1 chk("t5_inval_hi", 64'(if0.uart_in_valid), 64'h1);
        @(posedge clk); #1;
        t_en = 1'b0;
        #1 chk("t5_inval_lo", 64'(if0.uart_in_valid), 64'h0);
        @(negedge clk);
        chk("t5_rxdata", if0.conf_rdata, 64'h41);
        acc(8'h28, 8'h00, 64'h0);
        @(negedge clk);
        chk("t5_unmapped", if0.conf_rdata, 64'h0);
        acc(8'h28, 8'hFF, 64'hDEAD_BEEF_0000_0001);
        idle(2);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            int r;
            t_in_ch = 8'($urandom);
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2, 3: acc(8'h00, ($urandom_range(0, 3) == 0) ? (8'($urandom) | 8'h02) : 8'h01, 64'($urandom));
                4: acc(offs[$urandom_range(0, 7)], 8'h00, 64'($urandom));
                5: acc(8'h08, 8'($urandom) | 8'h80, {32'($urandom), 32'($urandom)});
                6: acc(8'h18, 8'($urandom) | 8'h01,
                       ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFF0 : {32'($urandom), 32'($urandom)});
                7: acc(8'h20, 8'($urandom) | 8'h01, m_mtime[0] + 64'($urandom_range(0, 40)));
                8: acc_raw({BASE[63:8] ^ 56'($urandom_range(1, 255)), 8'h00}, 8'($urandom), 64'($urandom));
                default: idle(1);
            endcase
        end
        idle(100);

        // Reset while the gap-4 instance is draining
        for (int i = 0; i < 7; i++) acc(8'h00, 8'h01, 64'(8'h60 + 8'(i)));
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (if4.uart_out_valid) begin
                found = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("t6_pulse_seen", 64'(found), 64'h1);
        #1 rst_n = 1'b0;
        #1 chk("t6_valid_drop", 64'(if4.uart_out_valid), 64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        acc(8'h08, 8'h00, 64'h0);
        @(negedge clk);
        chk("t6_status4", if4.conf_rdata, 64'h2);
        chk("t6_status0", if0.conf_rdata, 64'h2);
        idle(30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
